// File: rtl/core.sv
// Single-cycle RV32I-subset core with combinational ROM, register file and data RAM.
// Define CORE_BRANCH_EN to enable BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR.

module core_imem #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [31:0] i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_addr,
    output logic [31:0] o_rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]   rom_data [0:WORDS-1];
    logic [AW-1:0] w_ridx;
    logic [AW-1:0] w_widx;
    logic          w_unused_ok;

    assign w_ridx      = AW'({2'b00, i_addr[31:2]} % WORDS);
    assign w_widx      = AW'({2'b00, i_waddr[31:2]} % WORDS);
    assign o_rdata     = rom_data[w_ridx];
    assign w_unused_ok = &{1'b0, i_addr[1:0], i_waddr[1:0]};

    // Contents are normally preloaded from outside; this load port is held idle by core.
    always_ff @(posedge clk) begin
        if (i_we) begin
            rom_data[w_widx] <= i_wdata;
        end
    end
endmodule

module core_regfile (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic        i_we,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);
    logic [31:0] reg_data [0:31];

    assign o_rs1_data = reg_data[i_rs1];
    assign o_rs2_data = reg_data[i_rs2];

    // x0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                reg_data[i] <= 32'b0;
            end
        end else if (i_we && (i_rd != 5'd0)) begin
            reg_data[i_rd] <= i_wdata;
        end
    end
endmodule

module core_dmem #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]   ram_data [0:WORDS-1];
    logic [AW-1:0] w_idx;
    logic          w_unused_ok;

    assign w_idx       = AW'({2'b00, i_addr[31:2]} % WORDS);
    assign o_rdata     = ram_data[w_idx];
    assign w_unused_ok = &{1'b0, i_addr[1:0]};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                ram_data[i] <= 32'b0;
            end
        end else if (i_we) begin
            ram_data[w_idx] <= i_wdata;
        end
    end
endmodule

module core #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input logic clk,
    input logic reset
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef CORE_BRANCH_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    logic [31:0] r_pc;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_rdata;
    logic        w_mem_we;
    logic        w_rf_we;
    logic [31:0] w_wb_data;
    logic        w_r_legal;
    logic        w_i_legal;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  alu = alt ? (a - b) : (a + b);
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'b0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    assign w_opcode   = w_instr[6:0];
    assign w_rd       = w_instr[11:7];
    assign w_funct3   = w_instr[14:12];
    assign w_rs1      = w_instr[19:15];
    assign w_rs2      = w_instr[24:20];
    assign w_funct7   = w_instr[31:25];
    assign w_imm_i    = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_u    = {w_instr[31:12], 12'b0};
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_mem_addr = w_rs1_data + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);

    // funct7 only selects SUB/SRA; any other non-zero funct7 is treated as illegal.
    assign w_r_legal = (w_funct7 == 7'b0000000) ||
                       ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
    assign w_i_legal = (w_funct3 == 3'b001) ? (w_funct7 == 7'b0000000) :
                       (w_funct3 == 3'b101) ? ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000)) :
                       1'b1;

`ifdef CORE_BRANCH_EN
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic        w_br_taken;

    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_br_taken = (w_rs1_data == w_rs2_data);
            3'b001:  w_br_taken = (w_rs1_data != w_rs2_data);
            3'b100:  w_br_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            3'b101:  w_br_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            3'b110:  w_br_taken = (w_rs1_data <  w_rs2_data);
            3'b111:  w_br_taken = (w_rs1_data >= w_rs2_data);
            default: w_br_taken = 1'b0;
        endcase
    end
`endif

    always_comb begin
        w_rf_we   = 1'b0;
        w_wb_data = 32'b0;
        w_mem_we  = 1'b0;
        w_next_pc = w_pc_plus4;
        case (w_opcode)
            OP_R: begin
                if (w_r_legal) begin
                    w_rf_we   = 1'b1;
                    w_wb_data = alu(w_funct3, w_funct7[5], w_rs1_data, w_rs2_data);
                end
            end
            OP_I: begin
                if (w_i_legal) begin
                    w_rf_we   = 1'b1;
                    w_wb_data = alu(w_funct3, (w_funct3 == 3'b101) && w_funct7[5], w_rs1_data, w_imm_i);
                end
            end
            OP_LOAD: begin
                if (w_funct3 == 3'b010) begin
                    w_rf_we   = 1'b1;
                    w_wb_data = w_mem_rdata;
                end
            end
            OP_STORE: begin
                w_mem_we = (w_funct3 == 3'b010);
            end
            OP_LUI: begin
                w_rf_we   = 1'b1;
                w_wb_data = w_imm_u;
            end
            OP_AUIPC: begin
                w_rf_we   = 1'b1;
                w_wb_data = r_pc + w_imm_u;
            end
`ifdef CORE_BRANCH_EN
            OP_BRANCH: begin
                if (w_br_taken) begin
                    w_next_pc = r_pc + w_imm_b;
                end
            end
            OP_JAL: begin
                w_rf_we   = 1'b1;
                w_wb_data = w_pc_plus4;
                w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_rf_we   = 1'b1;
                    w_wb_data = w_pc_plus4;
                    w_next_pc = (w_rs1_data + w_imm_i) & ~32'd1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= 32'b0;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    core_imem #(.WORDS(IMEM_WORDS)) inst_mem (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr (32'b0),
        .i_wdata (32'b0),
        .i_addr  (r_pc),
        .o_rdata (w_instr)
    );

    core_regfile reg_cpu (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .i_we       (w_rf_we),
        .i_rd       (w_rd),
        .i_wdata    (w_wb_data),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    core_dmem #(.WORDS(DMEM_WORDS)) data_mem (
        .clk     (clk),
        .i_rst_n (reset),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_rs2_data),
        .o_rdata (w_mem_rdata)
    );
endmodule

// File: tb/tb_core.sv
// Directed testbench for core: programs are written into the ROM hierarchically,
// and pc, registers and RAM are compared against hand-computed values.
`timescale 1ns/1ps

module tb_core;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    core dut (
        .clk   (clk),
        .reset (reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        enc_i = {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        enc_r = {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        enc_s = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        enc_u = {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        enc_b = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        enc_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic clear_rom();
        for (int k = 0; k < 64; k++) dut.inst_mem.rom_data[k] = 32'h0000_0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int nz;
        reset = 1'b0;
        clear_rom();
        dut.inst_mem.rom_data[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd1, OP_I);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut.r_pc !== 32'd0) begin
            n_errors++; $display("FAIL reset_pc: got %h expected %h", dut.r_pc, 32'd0);
        end
        nz = 0;
        for (int k = 0; k < 32; k++) if (dut.reg_cpu.reg_data[k] !== 32'd0) nz++;
        n_checks++;
        if (nz !== 0) begin
            n_errors++; $display("FAIL reset_regs: nonzero registers %0d expected 0", nz);
        end
        nz = 0;
        for (int k = 0; k < 64; k++) if (dut.data_mem.ram_data[k] !== 32'd0) nz++;
        n_checks++;
        if (nz !== 0) begin
            n_errors++; $display("FAIL reset_ram: nonzero words %0d expected 0", nz);
        end
        @(negedge clk);
        reset = 1'b1;
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[1] !== 32'd9 || dut.r_pc !== 32'd4) begin
            n_errors++; $display("FAIL reset_first_instr: x1 %h pc %h expected x1 9 pc 4", dut.reg_cpu.reg_data[1], dut.r_pc);
        end
    endtask

    task automatic test_arith();
        clear_rom();
        dut.inst_mem.rom_data[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_I);
        dut.inst_mem.rom_data[1] = enc_i(12'd3, 5'd0, 3'b000, 5'd2, OP_I);
        dut.inst_mem.rom_data[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd1);
        dut.inst_mem.rom_data[3] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd1);
        dut.inst_mem.rom_data[4] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd1);
        dut.inst_mem.rom_data[5] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd3);
        dut.inst_mem.rom_data[6] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3);
        dut.inst_mem.rom_data[7] = enc_s(12'd0, 5'd2, 5'd1);
        dut.inst_mem.rom_data[8] = enc_i(12'd0, 5'd1, 3'b010, 5'd1, OP_LOAD);
        do_reset();
        step(2);
        n_checks++;
        if (dut.reg_cpu.reg_data[2] !== 32'd3) begin
            n_errors++; $display("FAIL addi_x2: got %h expected %h", dut.reg_cpu.reg_data[2], 32'd3);
        end
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[1] !== 32'd8) begin
            n_errors++; $display("FAIL add_edge3: got %h expected %h", dut.reg_cpu.reg_data[1], 32'd8);
        end
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[1] !== 32'd11) begin
            n_errors++; $display("FAIL add_edge4: got %h expected %h", dut.reg_cpu.reg_data[1], 32'd11);
        end
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[1] !== 32'd8) begin
            n_errors++; $display("FAIL sub: got %h expected %h", dut.reg_cpu.reg_data[1], 32'd8);
        end
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[3] !== 32'd11) begin
            n_errors++; $display("FAIL or: got %h expected %h", dut.reg_cpu.reg_data[3], 32'd11);
        end
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[3] !== 32'd0) begin
            n_errors++; $display("FAIL and: got %h expected %h", dut.reg_cpu.reg_data[3], 32'd0);
        end
        step(1);
        n_checks++;
        if (dut.data_mem.ram_data[2] !== 32'd3) begin
            n_errors++; $display("FAIL sw_ram2: got %h expected %h", dut.data_mem.ram_data[2], 32'd3);
        end
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[1] !== 32'd3) begin
            n_errors++; $display("FAIL lw_x1: got %h expected %h", dut.reg_cpu.reg_data[1], 32'd3);
        end
        n_checks++;
        if (dut.r_pc !== 32'd36) begin
            n_errors++; $display("FAIL arith_pc: got %h expected %h", dut.r_pc, 32'd36);
        end
    endtask

    task automatic test_alu_misc();
        clear_rom();
        dut.inst_mem.rom_data[0]  = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OP_I);
        dut.inst_mem.rom_data[1]  = enc_u(20'h80000, 5'd5, OP_LUI);
        dut.inst_mem.rom_data[2]  = enc_i(12'h404, 5'd5, 3'b101, 5'd6, OP_I);
        dut.inst_mem.rom_data[3]  = enc_i(12'h004, 5'd5, 3'b101, 5'd7, OP_I);
        dut.inst_mem.rom_data[4]  = enc_r(7'b0000000, 5'd0, 5'd5, 3'b010, 5'd9);
        dut.inst_mem.rom_data[5]  = enc_r(7'b0000000, 5'd0, 5'd5, 3'b011, 5'd10);
        dut.inst_mem.rom_data[6]  = enc_i(12'hFFF, 5'd5, 3'b100, 5'd13, OP_I);
        dut.inst_mem.rom_data[7]  = enc_i(12'd33, 5'd0, 3'b000, 5'd15, OP_I);
        dut.inst_mem.rom_data[8]  = enc_i(12'd1, 5'd0, 3'b000, 5'd16, OP_I);
        dut.inst_mem.rom_data[9]  = enc_r(7'b0000000, 5'd15, 5'd16, 3'b001, 5'd14);
        dut.inst_mem.rom_data[10] = enc_r(7'b0100000, 5'd16, 5'd0, 3'b000, 5'd17);
        dut.inst_mem.rom_data[11] = enc_r(7'b0000000, 5'd16, 5'd13, 3'b000, 5'd18);
        dut.inst_mem.rom_data[12] = enc_u(20'h00001, 5'd11, OP_AUIPC);
        dut.inst_mem.rom_data[13] = 32'hFFFF_FFFF;
        dut.inst_mem.rom_data[14] = 32'h0000_0000;
        dut.inst_mem.rom_data[15] = enc_i(12'd0, 5'd5, 3'b010, 5'd12, OP_I);
        dut.inst_mem.rom_data[16] = enc_i(12'hFFF, 5'd16, 3'b011, 5'd19, OP_I);
        dut.inst_mem.rom_data[17] = enc_r(7'b0000001, 5'd16, 5'd16, 3'b000, 5'd21);
        do_reset();
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[0] !== 32'd0) begin
            n_errors++; $display("FAIL x0_write: got %h expected %h", dut.reg_cpu.reg_data[0], 32'd0);
        end
        step(17);
        n_checks++;
        if (dut.reg_cpu.reg_data[6] !== 32'hF800_0000) begin
            n_errors++; $display("FAIL srai: got %h expected %h", dut.reg_cpu.reg_data[6], 32'hF800_0000);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[7] !== 32'h0800_0000) begin
            n_errors++; $display("FAIL srli: got %h expected %h", dut.reg_cpu.reg_data[7], 32'h0800_0000);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[9] !== 32'd1 || dut.reg_cpu.reg_data[10] !== 32'd0) begin
            n_errors++; $display("FAIL slt_sltu: got %h %h expected 1 0", dut.reg_cpu.reg_data[9], dut.reg_cpu.reg_data[10]);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[13] !== 32'h7FFF_FFFF) begin
            n_errors++; $display("FAIL xori: got %h expected %h", dut.reg_cpu.reg_data[13], 32'h7FFF_FFFF);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[14] !== 32'd2) begin
            n_errors++; $display("FAIL sll_low5: got %h expected %h", dut.reg_cpu.reg_data[14], 32'd2);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[17] !== 32'hFFFF_FFFF || dut.reg_cpu.reg_data[18] !== 32'h8000_0000) begin
            n_errors++; $display("FAIL wrap: got %h %h expected ffffffff 80000000", dut.reg_cpu.reg_data[17], dut.reg_cpu.reg_data[18]);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[11] !== 32'h0000_1030) begin
            n_errors++; $display("FAIL auipc: got %h expected %h", dut.reg_cpu.reg_data[11], 32'h0000_1030);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[12] !== 32'd1 || dut.reg_cpu.reg_data[19] !== 32'd1) begin
            n_errors++; $display("FAIL slti_sltiu: got %h %h expected 1 1", dut.reg_cpu.reg_data[12], dut.reg_cpu.reg_data[19]);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[21] !== 32'd0 || dut.data_mem.ram_data[0] !== 32'd0) begin
            n_errors++; $display("FAIL illegal_nop: x21 %h ram0 %h expected 0 0", dut.reg_cpu.reg_data[21], dut.data_mem.ram_data[0]);
        end
        n_checks++;
        if (dut.r_pc !== 32'd72) begin
            n_errors++; $display("FAIL misc_pc: got %h expected %h", dut.r_pc, 32'd72);
        end
    endtask

    task automatic test_load_store();
        clear_rom();
        dut.inst_mem.rom_data[0] = enc_i(12'd11, 5'd0, 3'b000, 5'd1, OP_I);
        dut.inst_mem.rom_data[1] = enc_i(12'h055, 5'd0, 3'b000, 5'd2, OP_I);
        dut.inst_mem.rom_data[2] = enc_s(12'd0, 5'd2, 5'd1);
        dut.inst_mem.rom_data[3] = enc_i(12'h109, 5'd0, 3'b010, 5'd4, OP_LOAD);
        dut.inst_mem.rom_data[4] = enc_i(12'd16, 5'd0, 3'b000, 5'd5, OP_I);
        dut.inst_mem.rom_data[5] = enc_s(12'hFFC, 5'd1, 5'd5);
        dut.inst_mem.rom_data[6] = enc_i(12'hFFF, 5'd5, 3'b010, 5'd6, OP_LOAD);
        do_reset();
        step(3);
        n_checks++;
        if (dut.data_mem.ram_data[2] !== 32'h55) begin
            n_errors++; $display("FAIL sw_offset: got %h expected %h", dut.data_mem.ram_data[2], 32'h55);
        end
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[4] !== 32'h55) begin
            n_errors++; $display("FAIL lw_wrap: got %h expected %h", dut.reg_cpu.reg_data[4], 32'h55);
        end
        step(3);
        n_checks++;
        if (dut.data_mem.ram_data[3] !== 32'd11) begin
            n_errors++; $display("FAIL sw_negimm: got %h expected %h", dut.data_mem.ram_data[3], 32'd11);
        end
        n_checks++;
        if (dut.reg_cpu.reg_data[6] !== 32'd11) begin
            n_errors++; $display("FAIL lw_negimm: got %h expected %h", dut.reg_cpu.reg_data[6], 32'd11);
        end
    endtask

    task automatic test_pc_wrap();
        for (int k = 0; k < 64; k++) dut.inst_mem.rom_data[k] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, OP_I);
        do_reset();
        step(65);
        n_checks++;
        if (dut.reg_cpu.reg_data[1] !== 32'd65 || dut.r_pc !== 32'd260) begin
            n_errors++; $display("FAIL pc_wrap: x1 %h pc %h expected 41 104", dut.reg_cpu.reg_data[1], dut.r_pc);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] first;
        int nz;
        clear_rom();
        first = enc_i(12'd7, 5'd0, 3'b000, 5'd1, OP_I);
        dut.inst_mem.rom_data[0] = first;
        dut.inst_mem.rom_data[1] = enc_s(12'd0, 5'd1, 5'd0);
        dut.inst_mem.rom_data[2] = enc_i(12'd1, 5'd0, 3'b000, 5'd2, OP_I);
        do_reset();
        step(3);
        n_checks++;
        if (dut.data_mem.ram_data[0] !== 32'd7 || dut.reg_cpu.reg_data[2] !== 32'd1) begin
            n_errors++; $display("FAIL midrun_pre: ram0 %h x2 %h expected 7 1", dut.data_mem.ram_data[0], dut.reg_cpu.reg_data[2]);
        end
        #1;
        reset = 1'b0;
        #1;
        nz = 0;
        for (int k = 0; k < 32; k++) if (dut.reg_cpu.reg_data[k] !== 32'd0) nz++;
        for (int k = 0; k < 64; k++) if (dut.data_mem.ram_data[k] !== 32'd0) nz++;
        n_checks++;
        if (clk !== 1'b1 || dut.r_pc !== 32'd0 || nz !== 0) begin
            n_errors++; $display("FAIL midrun_async: clk %b pc %h nonzero %0d expected 1 0 0", clk, dut.r_pc, nz);
        end
        n_checks++;
        if (dut.inst_mem.rom_data[0] !== first) begin
            n_errors++; $display("FAIL rom_kept: got %h expected %h", dut.inst_mem.rom_data[0], first);
        end
        @(negedge clk);
        reset = 1'b1;
        step(1);
        n_checks++;
        if (dut.reg_cpu.reg_data[1] !== 32'd7 || dut.r_pc !== 32'd4 || dut.reg_cpu.reg_data[2] !== 32'd0) begin
            n_errors++; $display("FAIL midrun_restart: x1 %h pc %h x2 %h expected 7 4 0", dut.reg_cpu.reg_data[1], dut.r_pc, dut.reg_cpu.reg_data[2]);
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc;
        logic [31:0] exp_x1;
        logic [31:0] exp_x3;
        int nz;
        clear_rom();
        dut.inst_mem.rom_data[0] = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        dut.inst_mem.rom_data[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_I);
        dut.inst_mem.rom_data[2] = enc_i(12'd2, 5'd0, 3'b000, 5'd2, OP_I);
        do_reset();
        step(1);
`ifdef CORE_BRANCH_EN
        exp_pc = 32'd8;
`else
        exp_pc = 32'd4;
`endif
        nz = 0;
        for (int k = 0; k < 32; k++) if (dut.reg_cpu.reg_data[k] !== 32'd0) nz++;
        n_checks++;
        if (dut.r_pc !== exp_pc || nz !== 0) begin
            n_errors++; $display("FAIL beq: pc %h nonzero regs %0d expected pc %h and 0", dut.r_pc, nz, exp_pc);
        end
        clear_rom();
        dut.inst_mem.rom_data[0] = enc_j(21'd8, 5'd1);
        dut.inst_mem.rom_data[1] = enc_i(12'd9, 5'd0, 3'b000, 5'd5, OP_I);
        dut.inst_mem.rom_data[2] = enc_i(12'd1, 5'd1, 3'b000, 5'd3, OP_JALR);
        do_reset();
        step(3);
`ifdef CORE_BRANCH_EN
        exp_pc = 32'd8;  exp_x1 = 32'd4; exp_x3 = 32'd12;
`else
        exp_pc = 32'd12; exp_x1 = 32'd0; exp_x3 = 32'd0;
`endif
        n_checks++;
        if (dut.r_pc !== exp_pc || dut.reg_cpu.reg_data[1] !== exp_x1 ||
            dut.reg_cpu.reg_data[3] !== exp_x3 || dut.reg_cpu.reg_data[5] !== 32'd9) begin
            n_errors++; $display("FAIL jal_jalr: pc %h x1 %h x3 %h x5 %h expected %h %h %h 9", dut.r_pc,
                                 dut.reg_cpu.reg_data[1], dut.reg_cpu.reg_data[3], dut.reg_cpu.reg_data[5], exp_pc, exp_x1, exp_x3);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        test_reset();
        test_arith();
        test_alu_misc();
        test_load_store();
        test_pc_wrap();
        test_reset_midrun();
        test_branch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
